// File: rtl/instr_fetch_unit_pkg.sv
// rv32i_pkg: shared width, NOP encoding, fetch FSM states and queue entry layout.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem req/gnt/rvalid bus, execute redirect and decode valid/ready.
interface instr_fetch_unit_if import rv32i_pkg::*; ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            PCSel;
    logic [XLEN-1:0] pc_target;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc4;
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
        input  imem_gnt, imem_rvalid, imem_rdata, PCSel, pc_target, if_ready
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
        output imem_gnt, imem_rvalid, imem_rdata, PCSel, pc_target, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and push+pop when full.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_cnt;
    logic             w_full, w_empty, w_push, w_pop;
    assign w_full  = r_cnt == CW'(DEPTH);
    assign w_empty = r_cnt == '0;
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;
    always_ff @(posedge clk)
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr == AW'(DEPTH-1) ? '0 : r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd == AW'(DEPTH-1) ? '0 : r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk)
        if (!rst && !i_flush) begin
            assert (!(i_push && w_full && !i_pop));
            assert (!(i_pop && w_empty));
        end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end; owns the PC, issues imem reads, queues words in order.
module instr_fetch_unit import rv32i_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master io_bus
);
    localparam int CW = $clog2(QDEPTH+1);
    fetch_state_e    r_state, w_state_next;
    logic [XLEN-1:0] r_fpc, w_ret_pc, w_if_pc;
    logic [CW-1:0]   r_out, r_disc, w_out_next, w_disc_dec, w_q_count, w_pc_count;
    logic            w_issue, w_ret, w_push, w_pop, w_valid;
    if_entry_t       w_head;
    assign io_bus.imem_req  = (r_state != BOOT) && ({1'b0, r_out} + {1'b0, w_q_count} < (CW+1)'(QDEPTH));
    assign io_bus.imem_addr = r_fpc;
    assign w_issue    = io_bus.imem_req && io_bus.imem_gnt;
    assign w_ret      = io_bus.imem_rvalid && r_out != '0;
    assign w_out_next = r_out + CW'(w_issue) - CW'(w_ret);
    assign w_disc_dec = r_disc - CW'(w_ret && r_disc != '0);
    // A redirect flushes the queue, so nothing may enter or leave it that cycle.
    assign w_push     = w_ret && r_disc == '0 && !io_bus.PCSel;
    assign w_pop      = w_valid && io_bus.if_ready && !io_bus.PCSel;
    assign w_valid    = w_q_count != '0;
    assign w_if_pc    = w_valid ? w_head.pc : r_fpc;
    assign io_bus.if_valid = w_valid;
    assign io_bus.if_instr = w_valid ? w_head.instr : NOP_INSTR;
    assign io_bus.if_pc    = w_if_pc;
    assign io_bus.if_pc4   = w_if_pc + 32'd4;
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_pc_fifo (
        .clk(clk), .rst(rst), .i_push(w_issue), .i_pop(w_ret), .i_flush(1'b0),
        .i_data(r_fpc), .o_data(w_ret_pc), .o_count(w_pc_count)
    );
    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(QDEPTH)) u_q_fifo (
        .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(io_bus.PCSel),
        .i_data({io_bus.imem_rdata, w_ret_pc}), .o_data(w_head), .o_count(w_q_count)
    );
    always_comb begin
        w_state_next = r_state;
        if (r_state == BOOT) w_state_next = FETCH;
        else if (io_bus.PCSel) w_state_next = w_out_next != '0 ? FLUSH : FETCH;
        else if (r_state == FLUSH && w_disc_dec == '0) w_state_next = FETCH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_fpc   <= {RESET_PC[XLEN-1:2], 2'b00};
            r_out   <= '0;
            r_disc  <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_disc  <= io_bus.PCSel ? w_out_next : w_disc_dec;
            r_fpc   <= io_bus.PCSel ? {io_bus.pc_target[XLEN-1:2], 2'b00} : w_issue ? r_fpc + 32'd4 : r_fpc;
        end
    end
    always_ff @(posedge clk)
        if (!rst) begin
            assert (!io_bus.imem_rvalid || r_out != '0);
            assert (w_pc_count == r_out);
        end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario checks of instr_fetch_unit against hand-computed values.
module tb_instr_fetch_unit;
    import rv32i_pkg::*;
    localparam logic [31:0] K = 32'h1357_0000;
    logic clk = 0;
    logic rst = 1;
    bit hold = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] pend[$];
    logic p2;
    logic [31:0] a2;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();
    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut2 (.clk(clk), .rst(rst), .io_bus(bus2));

    // Memory for dut: in-order responses, one cycle after grant unless held back.
    always @(posedge clk)
        if (rst) pend.delete();
        else begin
            if (bus.imem_rvalid) void'(pend.pop_front());
            if (bus.imem_req && bus.imem_gnt) pend.push_back(bus.imem_addr);
        end
    always @(negedge clk) begin
        bus.imem_rvalid = !rst && !hold && pend.size() > 0;
        bus.imem_rdata  = 32'h0;
        if (bus.imem_rvalid) bus.imem_rdata = pend[0] ^ K;
    end
    always @(posedge clk)
        if (rst) p2 <= 1'b0;
        else begin
            p2 <= bus2.imem_req && bus2.imem_gnt;
            a2 <= bus2.imem_addr;
        end
    always_comb begin
        bus2.imem_rvalid = p2;
        bus2.imem_rdata  = a2 ^ K;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        bus.PCSel = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic get_instr(input logic [31:0] exp_pc);
        bit got = 0;
        logic [31:0] pc, instr;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.if_valid) begin
                pc = bus.if_pc;
                instr = bus.if_instr;
                got = 1;
            end
            tick();
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL get_instr timeout waiting for pc %h", exp_pc);
        end else if (pc !== exp_pc || instr !== (exp_pc ^ K)) begin
            n_fail++;
            $display("FAIL deliver got pc %h instr %h, expected pc %h instr %h", pc, instr, exp_pc, exp_pc ^ K);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_instr !== NOP_INSTR) begin
            n_fail++;
            $display("FAIL reset_outs got req %b valid %b instr %h, expected 0 0 %h", bus.imem_req, bus.if_valid, bus.if_instr, NOP_INSTR);
        end
        n_tests++;
        if (bus.if_pc !== 32'h0 || bus.if_pc4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_pc got %h/%h, expected 0/4", bus.if_pc, bus.if_pc4);
        end
        n_tests++;
        if (bus2.if_pc !== 32'hFFFF_FFFC || bus2.if_pc4 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc2 got %h/%h, expected fffffffc/0", bus2.if_pc, bus2.if_pc4);
        end
    endtask

    task automatic test_stream;
        bus.if_ready = 1;
        hold = 0;
        do_reset();
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_req got %b, expected 0", bus.imem_req);
        end
        tick();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req got %b addr %h, expected 1 0", bus.imem_req, bus.imem_addr);
        end
        tick();
        n_tests++;
        if (bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL second_req got addr %h valid %b, expected 4 0", bus.imem_addr, bus.if_valid);
        end
        tick();
        n_tests++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_pc4 !== 32'h4 || bus.if_instr !== K) begin
            n_fail++;
            $display("FAIL first_valid got v %b pc %h pc4 %h instr %h, expected 1 0 4 %h", bus.if_valid, bus.if_pc, bus.if_pc4, bus.if_instr, K);
        end
        for (int i = 0; i < 3; i++) get_instr(32'(i * 4));
    endtask

    task automatic test_stall;
        bus.if_ready = 0;
        hold = 0;
        do_reset();
        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall got v %b pc %h req %b, expected 1 0 0", bus.if_valid, bus.if_pc, bus.imem_req);
            end
            tick();
            tick();
        end
        bus.if_ready = 1;
        for (int i = 0; i < 3; i++) get_instr(32'(i * 4));
    endtask

    task automatic test_redirect;
        bus.if_ready = 1;
        hold = 1;
        do_reset();
        repeat (4) tick();
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_outstanding got req %b valid %b, expected 0 0", bus.imem_req, bus.if_valid);
        end
        bus.PCSel = 1;
        bus.pc_target = 32'h0000_0103;
        tick();
        bus.PCSel = 0;
        hold = 0;
        n_tests++;
        if (bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_addr got %h valid %b, expected 100 0", bus.imem_addr, bus.if_valid);
        end
        get_instr(32'h100);
        get_instr(32'h104);
    endtask

    task automatic test_redirect_collide;
        bus.if_ready = 1;
        hold = 0;
        do_reset();
        tick();
        tick();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL collide_pre got req %b addr %h, expected 1 4", bus.imem_req, bus.imem_addr);
        end
        bus.PCSel = 1;
        bus.pc_target = 32'h0000_0200;
        tick();
        bus.PCSel = 0;
        n_tests++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL collide_post got valid %b addr %h, expected 0 200", bus.if_valid, bus.imem_addr);
        end
        get_instr(32'h200);
        get_instr(32'h204);
    endtask

    task automatic test_wrap;
        do_reset();
        tick();
        n_tests++;
        if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_addr0 got req %b addr %h, expected 1 fffffffc", bus2.imem_req, bus2.imem_addr);
        end
        tick();
        n_tests++;
        if (bus2.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr1 got %h, expected 0", bus2.imem_addr);
        end
        tick();
        n_tests++;
        if (bus2.if_valid !== 1'b1 || bus2.if_pc !== 32'hFFFF_FFFC || bus2.if_pc4 !== 32'h0 || bus2.if_instr !== 32'hECA8_FFFC) begin
            n_fail++;
            $display("FAIL wrap_deliver got v %b pc %h pc4 %h instr %h, expected 1 fffffffc 0 eca8fffc", bus2.if_valid, bus2.if_pc, bus2.if_pc4, bus2.if_instr);
        end
    endtask

    task automatic test_reset_midstream;
        bus.if_ready = 0;
        hold = 0;
        do_reset();
        repeat (6) tick();
        n_tests++;
        if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_rst got v %b req %b, expected 1 0", bus.if_valid, bus.imem_req);
        end
        #2 rst = 1;
        #1;
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_instr !== NOP_INSTR || bus.if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst got req %b v %b instr %h pc %h, expected 0 0 %h 0", bus.imem_req, bus.if_valid, bus.if_instr, bus.if_pc, NOP_INSTR);
        end
        tick();
        rst = 0;
        tick();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL restart got req %b addr %h, expected 1 0", bus.imem_req, bus.imem_addr);
        end
    endtask

    initial begin
        bus.imem_gnt = 1;
        bus.PCSel = 0;
        bus.pc_target = 0;
        bus.if_ready = 1;
        bus2.imem_gnt = 1;
        bus2.PCSel = 0;
        bus2.pc_target = 0;
        bus2.if_ready = 1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d tests", n_tests);
        $fatal(1);
    end
endmodule
